bcd_serial_adder: RTL



---
 rtl/bcd_pkg.sv | 12 +
 rtl/bcd_digit_adder.sv | 25 ++
 rtl/bcd_serial_adder.sv | 99 +++++++++
 3 files changed

// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared constants and state type for the serial BCD adder
package bcd_pkg;
    localparam int DIGIT_W  = 4;
    localparam int BCD_MAX  = 9;
    localparam int BCD_CORR = 6;

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;
endpackage

// File: rtl/bcd_digit_adder.sv
// rtl/bcd_digit_adder.sv - combinational single-digit BCD adder with +6 correction
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               c_in,
    output logic [DIGIT_W-1:0] s,
    output logic               c_out
);

    logic [DIGIT_W:0] z;

    always_comb begin
        z = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, c_in};
        if (z > (DIGIT_W+1)'(BCD_MAX)) begin
            s     = z[DIGIT_W-1:0] + DIGIT_W'(BCD_CORR);
            c_out = 1'b1;
        end else begin
            s     = z[DIGIT_W-1:0];
            c_out = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// rtl/bcd_serial_adder.sv - multi-digit BCD adder sharing one digit adder, LSD first
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [DIGIT_W*DIGITS-1:0] a,
    input  logic [DIGIT_W*DIGITS-1:0] b,
    input  logic                    c_in,
    output logic                    busy,
    output logic                    done,
    output logic [DIGIT_W*DIGITS-1:0] s,
    output logic                    c_out,
    output logic                    err
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int W     = DIGIT_W * DIGITS;

    state_t             state, state_nxt;
    logic [W-1:0]       a_q, b_q, s_q;
    logic [IDX_W-1:0]   idx_q;
    logic               carry_q, c_out_q, err_q;
    logic [DIGIT_W-1:0] a_dig, b_dig, sum_dig;
    logic               dig_carry, last_dig, dig_bad;

    assign a_dig    = a_q[DIGIT_W*idx_q +: DIGIT_W];
    assign b_dig    = b_q[DIGIT_W*idx_q +: DIGIT_W];
    assign last_dig = (idx_q == IDX_W'(DIGITS-1));
    assign dig_bad  = (a_dig > DIGIT_W'(BCD_MAX)) || (b_dig > DIGIT_W'(BCD_MAX));

    bcd_digit_adder u_digit (
        .a     (a_dig),
        .b     (b_dig),
        .c_in  (carry_q),
        .s     (sum_dig),
        .c_out (dig_carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ADD;
            ADD:     if (last_dig) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Operands are captured at start so later input changes cannot disturb the sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            c_out_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        carry_q <= c_in;
                        s_q     <= '0;
                        idx_q   <= '0;
                        c_out_q <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                ADD: begin
                    s_q[DIGIT_W*idx_q +: DIGIT_W] <= sum_dig;
                    carry_q <= dig_carry;
                    err_q   <= err_q | dig_bad;
                    if (last_dig) c_out_q <= dig_carry;
                    else          idx_q   <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state != IDLE);
    assign done  = (state == DONE);
    assign s     = s_q;
    assign c_out = c_out_q;
    assign err   = err_q;

endmodule
